tt_sweep_extractor: RTL and testbench
=====================================

Name: tt_sweep_extractor

Overview:
- Sequential characterization engine for 7-input Boolean function blocks (majority-gate netlists and similar).
- Drives all 128 input minterms into a function-under-test (FUT), samples its single-bit output, and rebuilds the 128-bit truth table.
- Compares the rebuilt table bit-by-bit against an expected table and reports the mismatch count.
- Sits in the classification bench / on-chip self-check wrapper around each generated function netlist.

Parameters:
- N_IN, 7, FUT input count; fixed at 7 (TT_W = 2**N_IN = 128).
- FUT_LAT, 0, clock edges between applying x and the FUT output valid at f_in; 0 means FUT is purely combinational; legal range 0..7.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; honoured only in IDLE.
- busy  output  1  high in SWEEP and DRAIN.
- x  output  7  minterm driven to FUT; x[0] is FUT input x0.
- f_in  input  1  FUT output.
- exp_tt  input  128  expected table; bit i = f(i); must be stable from start until tt_valid.
- tt  output  128  rebuilt table; bit i = f(x==i).
- tt_valid  output  1  result available; held until handshake.
- tt_ready  input  1  consumer accepts result when tt_valid & tt_ready.
- mismatch  output  1  (mismatch_cnt != 0); meaningful only while tt_valid.
- mismatch_cnt  output  8  number of differing bits, 0..128.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, x=0, tt=0, tt_valid=0, mismatch_cnt=0, mismatch=0.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - start=1 at an edge -> SWEEP. issue_idx and cap_idx are cleared to 0; mismatch_cnt is cleared.
- SWEEP:
  - x = issue_idx. issue_idx increments every cycle.
  - After the cycle with x=127: go to DRAIN if FUT_LAT>0, otherwise go to DONE.
- DRAIN:
  - Lasts exactly FUT_LAT cycles. x holds 127.
- Capture:
  - Begins FUT_LAT edges after the first SWEEP edge.
  - For 128 consecutive edges: tt <= {f_in, tt[127:1]}, so after 128 shifts bit 0 = f(0).
  - On each capture: if f_in != exp_tt[cap_idx], mismatch_cnt += 1; then cap_idx += 1.
- Timing:
  - For the first SWEEP cycle, x=0.
  - For start sampled at edge E0, tt_valid goes high after edge E0+128+FUT_LAT.
  - Total latency is 128+FUT_LAT cycles.
- DONE:
  - tt_valid=1. tt, mismatch and mismatch_cnt are frozen.
  - x returns to 0.
  - On tt_valid & tt_ready -> IDLE, and tt_valid=0 next cycle.
  - tt and mismatch_cnt keep their values until the next start.
- Boundary rules:
  - start in SWEEP, DRAIN or DONE is ignored and not queued. start in the handshake cycle is ignored.
  - start held high continuously launches a new sweep on the first IDLE edge, i.e. one cycle after handshake.
  - tt_ready low in DONE is backpressure with no timeout; outputs are held stable.
  - rst mid-sweep abandons the partial table; all outputs take reset values on the next edge.
  - mismatch_cnt range is 0..128 and does not wrap.
  - Counters: issue_idx and cap_idx are 7 bits plus a terminal flag. Wrap at 127 is never used to re-issue.

Decomposition:
- Package tt_pkg holds:
  - N_IN=7, TT_W=128;
  - the state enum {IDLE, SWEEP, DRAIN, DONE};
  - the mismatch count width = 8.
- Sub-module tt_capture holds the 128-bit shift register, cap_idx, the exp_tt bit select and mismatch_cnt.
- The FSM and issue counter stay in the top level.

Test Plan:
- FUT f=maj(x0,x1,x2), FUT_LAT=0, exp_tt=0xE8 repeated 16 times:
  - tt=0xE8E8...E8;
  - mismatch=0, mismatch_cnt=0;
  - tt_valid rises exactly 128 edges after start.
- FUT f=x6, exp_tt=0:
  - tt=0xFFFFFFFFFFFFFFFF_0000000000000000;
  - mismatch_cnt=64, mismatch=1.
- FUT f=1 registered twice (FUT_LAT=2), exp_tt=0xAAAA...AA:
  - tt=all ones, mismatch_cnt=64;
  - tt_valid at start+130 edges;
  - x holds 127 during the 2 DRAIN cycles.
- Backpressure:
  - tt_ready low 10 cycles after tt_valid -> tt and mismatch_cnt stable, start pulses ignored;
  - tt_ready=1 -> IDLE, tt_valid=0 next cycle.
- Reset mid-sweep:
  - rst when x=40 -> next cycle busy=0, x=0, tt=0, tt_valid=0;
  - a restart with f=x0 yields tt=0xAAAA...AA and correct timing.
- start held high through handshake -> new sweep begins one cycle after handshake with x=0, and mismatch_cnt is cleared.

Source files
------------

// File: rtl/tt_sweep_extractor_pkg.sv
// ============================================================================
//  Package    : tt_pkg
//  Description: Shared widths and FSM state encoding for the truth-table
//               sweep extractor (7-input function characterization).
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package tt_pkg;

    // Function-under-test input count and resulting truth-table width
    localparam int N_IN  = 7;
    localparam int TT_W  = 1 << N_IN;

    // Mismatch counter must reach 128 without wrapping, hence 8 bits
    localparam int CNT_W = 8;

    // Sweep controller states (explicit 2-bit encoding)
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SWEEP = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t DONE  = 2'd3;

endpackage : tt_pkg

`default_nettype wire

// File: rtl/tt_sweep_extractor_capture.sv
// ============================================================================
//  Module     : tt_capture
//  Description: Truth-table capture datapath. Shifts the FUT output into a
//               128-bit register (LSB-first after a full sweep), walks the
//               expected table with a capture index and counts mismatches.
//  Ports      : clk, rst        - clock, synchronous active-high reset
//               i_clr           - clear table, index and count (sweep start)
//               i_cap_en        - FUT output is valid this cycle
//               i_f             - FUT output bit
//               i_exp_tt        - expected truth table
//               o_tt            - rebuilt truth table
//               o_mismatch_cnt  - number of differing bits (0..128)
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_capture
    import tt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_cap_en,
    input  logic             i_f,
    input  logic [TT_W-1:0]  i_exp_tt,
    output logic [TT_W-1:0]  o_tt,
    output logic [CNT_W-1:0] o_mismatch_cnt
);

    logic [TT_W-1:0]  r_tt;
    logic [N_IN-1:0]  r_cap_idx;
    logic             r_cap_full;
    logic [CNT_W-1:0] r_cnt;
    logic             w_exp_bit;

    assign w_exp_bit = i_exp_tt[r_cap_idx];

    // r_cap_full is the terminal flag: once 128 bits are in, further enables
    // are ignored, so the 7-bit index wrapping to 0 can never re-capture.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_tt       <= '0;
            r_cap_idx  <= '0;
            r_cap_full <= 1'b0;
            r_cnt      <= '0;
        end else if (i_cap_en && !r_cap_full) begin
            // Shift in from the top: after 128 shifts bit i holds f(i)
            r_tt      <= {i_f, r_tt[TT_W-1:1]};
            r_cap_idx <= r_cap_idx + 1'b1;
            if (i_f != w_exp_bit) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cap_idx == '1) begin
                r_cap_full <= 1'b1;
            end
        end
    end

    assign o_tt           = r_tt;
    assign o_mismatch_cnt = r_cnt;

endmodule : tt_capture

`default_nettype wire

// File: rtl/tt_sweep_extractor.sv
// ============================================================================
//  Module     : tt_sweep_extractor
//  Description: Drives all 128 minterms into a 7-input function-under-test,
//               rebuilds its truth table and compares it with an expected
//               table. FUT_LAT covers registered FUTs (0 = combinational).
//  Ports      : clk, rst              - clock, synchronous active-high reset
//               start                 - request a sweep (honoured in IDLE)
//               busy                  - sweep or drain in progress
//               x                     - minterm driven to the FUT
//               f_in                  - FUT output
//               exp_tt                - expected table, bit i = f(i)
//               tt                    - rebuilt table, bit i = f(i)
//               tt_valid / tt_ready   - result handshake
//               mismatch              - any differing bit
//               mismatch_cnt          - number of differing bits
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_sweep_extractor #(
    parameter int N_IN    = 7,
    parameter int FUT_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic [N_IN-1:0]      x,
    input  logic                 f_in,
    input  logic [(2**N_IN)-1:0] exp_tt,
    output logic [(2**N_IN)-1:0] tt,
    output logic                 tt_valid,
    input  logic                 tt_ready,
    output logic                 mismatch,
    output logic [7:0]           mismatch_cnt
);

    import tt_pkg::*;

    localparam int LAT_W = 3;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_IN-1:0]  r_issue_idx;
    logic [LAT_W-1:0] r_drain_cnt;
    logic             w_start_sweep;
    logic             w_issue;
    logic             w_issue_last;
    logic             w_drain_last;
    logic             w_cap_en;

    assign w_start_sweep = (r_state == IDLE) && start;
    assign w_issue       = (r_state == SWEEP);
    assign w_issue_last  = (r_issue_idx == '1);
    // Only evaluated in DRAIN, which exists only when FUT_LAT > 0
    assign w_drain_last  = (r_drain_cnt == LAT_W'(FUT_LAT - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        tt_valid    = 1'b0;
        x           = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                busy = 1'b1;
                x    = r_issue_idx;
                if (w_issue_last) begin
                    w_state_nxt = (FUT_LAT > 0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                // Hold the last minterm while the FUT pipeline empties
                busy = 1'b1;
                x    = '1;
                if (w_drain_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                tt_valid = 1'b1;
                if (tt_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue and drain counters. The issue index wraps to 0 on the same
    // edge that leaves SWEEP, so the wrapped value is never driven.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_idx <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_start_sweep) begin
                r_issue_idx <= '0;
            end else if (w_issue) begin
                r_issue_idx <= r_issue_idx + 1'b1;
            end

            if (r_state == DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture enable: the issue strobe delayed by the FUT latency
    // ------------------------------------------------------------------
    generate
        if (FUT_LAT == 0) begin : g_lat_comb
            assign w_cap_en = w_issue;
        end else begin : g_lat_pipe
            logic [FUT_LAT-1:0] r_issue_pipe;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_issue_pipe <= '0;
                end else begin
                    r_issue_pipe <= (r_issue_pipe << 1) | FUT_LAT'(w_issue);
                end
            end

            assign w_cap_en = r_issue_pipe[FUT_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Capture datapath
    // ------------------------------------------------------------------
    tt_capture u_capture (
        .clk            (clk),
        .rst            (rst),
        .i_clr          (w_start_sweep),
        .i_cap_en       (w_cap_en),
        .i_f            (f_in),
        .i_exp_tt       (exp_tt),
        .o_tt           (tt),
        .o_mismatch_cnt (mismatch_cnt)
    );

    assign mismatch = (mismatch_cnt != '0);

endmodule : tt_sweep_extractor

`default_nettype wire

// File: tb/tb_tt_sweep_extractor.sv
// ============================================================================
//  Module     : tb_tt_sweep_extractor
//  Description: Testbench for tt_sweep_extractor. Two instances share clock
//               and reset: dut0 with a combinational FUT (FUT_LAT=0) and
//               dut2 with a twice-registered FUT (FUT_LAT=2). Expected
//               results are queued at sweep start and checked by monitors.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tt_sweep_extractor;

    typedef struct {
        logic [127:0] tt;
        logic [7:0]   cnt;
        int           e0;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    // dut0 side
    logic         start0 = 1'b0, ready0 = 1'b1;
    logic         busy0, valid0, mm0, f0;
    logic [6:0]   x0;
    logic [127:0] exp0 = '0, tt0;
    logic [7:0]   cnt0;
    logic [1:0]   fsel0 = 2'd0;

    // dut2 side
    logic         start2 = 1'b0, ready2 = 1'b1;
    logic         busy2, valid2, mm2;
    logic [6:0]   x2;
    logic [127:0] exp2 = '0, tt2;
    logic [7:0]   cnt2;
    logic [1:0]   fsel2 = 2'd0;
    logic         r_f1 = 1'b0, r_f2 = 1'b0;

    exp_t q0[$];
    exp_t q2[$];
    exp_t m0, m2;
    logic pv0 = 1'b0, pv2 = 1'b0;
    int   e0_2;

    localparam logic [127:0] TT_MAJ = {16{8'hE8}};
    localparam logic [127:0] TT_X6  = {{64{1'b1}}, {64{1'b0}}};
    localparam logic [127:0] TT_ONE = {128{1'b1}};
    localparam logic [127:0] TT_X0  = {16{8'hAA}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FUT models: 0 maj(x0,x1,x2), 1 x6, 2 constant 1, 3 x0
    function automatic logic fut(input logic [1:0] s, input logic [6:0] v);
        case (s)
            2'd0:    fut = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
            2'd1:    fut = v[6];
            2'd2:    fut = 1'b1;
            default: fut = v[0];
        endcase
    endfunction

    assign f0 = fut(fsel0, x0);
    always @(posedge clk) begin
        r_f1 <= fut(fsel2, x2);
        r_f2 <= r_f1;
    end

    tt_sweep_extractor #(.N_IN(7), .FUT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .x(x0),
        .f_in(f0), .exp_tt(exp0), .tt(tt0), .tt_valid(valid0),
        .tt_ready(ready0), .mismatch(mm0), .mismatch_cnt(cnt0)
    );

    tt_sweep_extractor #(.N_IN(7), .FUT_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .x(x2),
        .f_in(r_f2), .exp_tt(exp2), .tt(tt2), .tt_valid(valid2),
        .tt_ready(ready2), .mismatch(mm2), .mismatch_cnt(cnt2)
    );

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", n, act, req);
        end
    endtask

    task automatic fail(input string n);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or no expectation queued", n);
    endtask

    // Monitors: pop one expectation on each rising tt_valid
    always @(negedge clk) begin
        if (valid0 && !pv0) begin
            if (q0.size() == 0) begin
                fail("mon0_unexpected");
            end else begin
                m0 = q0.pop_front();
                chk("mon0_tt", tt0, m0.tt);
                chk("mon0_cnt", 128'(cnt0), 128'(m0.cnt));
                chk("mon0_mismatch", 128'(mm0), 128'(m0.cnt != 8'd0));
                chk("mon0_latency", 128'(cyc - m0.e0), 128'(m0.lat));
            end
        end
        pv0 <= valid0;
    end

    always @(negedge clk) begin
        if (valid2 && !pv2) begin
            if (q2.size() == 0) begin
                fail("mon2_unexpected");
            end else begin
                m2 = q2.pop_front();
                chk("mon2_tt", tt2, m2.tt);
                chk("mon2_cnt", 128'(cnt2), 128'(m2.cnt));
                chk("mon2_mismatch", 128'(mm2), 128'(m2.cnt != 8'd0));
                chk("mon2_latency", 128'(cyc - m2.e0), 128'(m2.lat));
            end
        end
        pv2 <= valid2;
    end

    // Launch a sweep on dut0; returns at the negedge after the start edge
    task automatic go0(input logic [1:0] f, input logic [127:0] e,
                       input logic [127:0] ett, input logic [7:0] ecnt, input bit push);
        fsel0 = f;
        exp0  = e;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        chk("sweep0_first_x", 128'(x0), 128'(0));
        chk("sweep0_busy", 128'(busy0), 128'(1));
        if (push) q0.push_back('{tt: ett, cnt: ecnt, e0: cyc, lat: 128});
    endtask

    task automatic wait_valid0();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (valid0) return;
        end
        fail("wait_valid0");
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy0", 128'(busy0), 128'(0));
        chk("rst_x0", 128'(x0), 128'(0));
        chk("rst_tt0", tt0, 128'(0));
        chk("rst_valid0", 128'(valid0), 128'(0));
        chk("rst_cnt0", 128'(cnt0), 128'(0));
        chk("rst_mm0", 128'(mm0), 128'(0));
        chk("rst_valid2", 128'(valid2), 128'(0));
        chk("rst_busy2", 128'(busy2), 128'(0));

        // Majority gate against its own table
        go0(2'd0, TT_MAJ, TT_MAJ, 8'd0, 1'b1);
        wait_valid0();
        @(negedge clk);

        // Registered constant-1 FUT with latency 2, check DRAIN behaviour
        fsel2 = 2'd2;
        exp2  = TT_X0;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        e0_2 = cyc;
        q2.push_back('{tt: TT_ONE, cnt: 8'd64, e0: e0_2, lat: 130});
        chk("sweep2_first_x", 128'(x2), 128'(0));
        repeat (128) @(negedge clk);
        chk("drain1_x", 128'(x2), 128'(127));
        chk("drain1_busy", 128'(busy2), 128'(1));
        chk("drain1_valid", 128'(valid2), 128'(0));
        @(negedge clk);
        chk("drain2_x", 128'(x2), 128'(127));
        chk("drain2_busy", 128'(busy2), 128'(1));
        @(negedge clk);
        chk("done2_x", 128'(x2), 128'(0));
        chk("done2_busy", 128'(busy2), 128'(0));
        @(negedge clk);

        // x6 against all-zero table, with backpressure
        ready0 = 1'b0;
        go0(2'd1, 128'(0), TT_X6, 8'd64, 1'b1);
        wait_valid0();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) start0 = 1'b1;
            if (i == 4) start0 = 1'b0;
            chk("bp_valid", 128'(valid0), 128'(1));
            chk("bp_tt", tt0, TT_X6);
            chk("bp_cnt", 128'(cnt0), 128'(64));
        end
        ready0 = 1'b1;
        @(negedge clk);
        chk("hs_valid_low", 128'(valid0), 128'(0));
        chk("hs_tt_hold", tt0, TT_X6);
        chk("hs_cnt_hold", 128'(cnt0), 128'(64));
        @(negedge clk);
        chk("hs_no_queued_start", 128'(busy0), 128'(0));

        // Reset in the middle of a sweep, then a clean restart
        go0(2'd3, TT_X0, TT_X0, 8'd0, 1'b0);
        begin : find40
            for (int i = 0; i < 200; i++) begin
                if (x0 == 7'd40) disable find40;
                @(negedge clk);
            end
            fail("wait_x40");
        end
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("mid_rst_busy", 128'(busy0), 128'(0));
        chk("mid_rst_x", 128'(x0), 128'(0));
        chk("mid_rst_tt", tt0, 128'(0));
        chk("mid_rst_valid", 128'(valid0), 128'(0));
        go0(2'd3, TT_X0, TT_X0, 8'd0, 1'b1);
        wait_valid0();
        @(negedge clk);

        // start held high through the handshake relaunches one cycle later
        fsel0 = 2'd0;
        exp0  = 128'(0);
        @(negedge clk) start0 = 1'b1;
        @(negedge clk);
        q0.push_back('{tt: TT_MAJ, cnt: 8'd64, e0: cyc, lat: 128});
        repeat (130) @(negedge clk);
        chk("relaunch_busy", 128'(busy0), 128'(1));
        chk("relaunch_x", 128'(x0), 128'(0));
        chk("relaunch_cnt_clr", 128'(cnt0), 128'(0));
        chk("relaunch_valid", 128'(valid0), 128'(0));
        q0.push_back('{tt: TT_MAJ, cnt: 8'd64, e0: cyc, lat: 128});
        start0 = 1'b0;
        wait_valid0();

        // Let monitors consume all remaining expectations
        for (int i = 0; i < 500; i++) begin
            if (q0.size() == 0 && q2.size() == 0) break;
            @(negedge clk);
        end
        while (q0.size() != 0) begin
            void'(q0.pop_front());
            fail("drain_q0");
        end
        while (q2.size() != 0) begin
            void'(q2.pop_front());
            fail("drain_q2");
        end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tt_sweep_extractor

`default_nettype wire
